// File: rtl/dmem_miss_sequencer_if.sv
// Lane-miss, memory-port and refill signals of the data-cache miss sequencer.
// master = sequencer side, slave = lanes/memory/cache side.
interface dmem_miss_sequencer_if #(
  parameter int b = 3
);
  logic        req_valid1, req_valid2;
  logic        req_write1, req_write2;
  logic [2:0]  req_size1,  req_size2;
  logic [63:0] req_addr1,  req_addr2;
  logic [63:0] req_data1,  req_data2;
  logic        req_ack1,   req_ack2;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_write;
  logic [63:0] mem_req_addr;
  logic [2:0]  mem_req_size;
  logic [7:0]  mem_req_len;
  logic [63:0] mem_req_data;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        mem_rlast;
  logic        mem_bvalid;
  logic        fill_valid;
  logic        fill_lane;
  logic [63:0] fill_addr;
  logic [b-1:0] fill_idx;
  logic [63:0] fill_data;
  logic        busy;
  logic        protocol_err;

  modport master (
    input  req_valid1, req_valid2, req_write1, req_write2, req_size1, req_size2,
           req_addr1, req_addr2, req_data1, req_data2,
           mem_req_ready, mem_rvalid, mem_rdata, mem_rlast, mem_bvalid,
    output req_ack1, req_ack2,
           mem_req_valid, mem_req_write, mem_req_addr, mem_req_size, mem_req_len, mem_req_data,
           fill_valid, fill_lane, fill_addr, fill_idx, fill_data, busy, protocol_err
  );

  modport slave (
    output req_valid1, req_valid2, req_write1, req_write2, req_size1, req_size2,
           req_addr1, req_addr2, req_data1, req_data2,
           mem_req_ready, mem_rvalid, mem_rdata, mem_rlast, mem_bvalid,
    input  req_ack1, req_ack2,
           mem_req_valid, mem_req_write, mem_req_addr, mem_req_size, mem_req_len, mem_req_data,
           fill_valid, fill_lane, fill_addr, fill_idx, fill_data, busy, protocol_err
  );
endinterface

// File: rtl/dmem_miss_sequencer.sv
// Serialises data-cache misses from two MEM lanes onto one memory request port:
// line-burst refills for read misses, single sized writes for write misses.
module dmem_miss_sequencer #(
  parameter int B = 8,
  parameter int b = 3,
  parameter int y = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dmem_miss_sequencer_if.master  bus
);

  typedef enum logic [2:0] {IDLE, REQ, RDATA, WRESP, DONE} state_e;

  typedef struct packed {
    logic        write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [63:0] data;
  } req_t;

  localparam logic [63:0]  LINE_MASK = ~((64'd1 << (b + y)) - 64'd1);
  localparam logic [b-1:0] LAST_BEAT = b'(B - 1);
  localparam logic [7:0]   BURST_LEN = 8'(B - 1);

  state_e       state_q, state_d;
  req_t         req_q, req_d;
  logic [1:0]   lane_q, lane_d;       // bit0 = lane 1, bit1 = lane 2
  logic [b-1:0] cnt_q, cnt_d;

  logic         mrv_q, mrv_d;
  logic         mrw_q, mrw_d;
  logic [63:0]  mra_q, mra_d;
  logic [2:0]   mrs_q, mrs_d;
  logic [7:0]   mrl_q, mrl_d;
  logic [63:0]  mrd_q, mrd_d;
  logic         fv_q, fv_d;
  logic         fl_q, fl_d;
  logic [63:0]  fa_q, fa_d;
  logic [b-1:0] fi_q, fi_d;
  logic [63:0]  fd_q, fd_d;
  logic [1:0]   ack_q, ack_d;
  logic         perr_q, perr_d;

  req_t         sel;
  logic [1:0]   grant;
  logic         merge;
  logic         last_beat;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    mrv_d   = mrv_q;
    mrw_d   = mrw_q;
    mra_d   = mra_q;
    mrs_d   = mrs_q;
    mrl_d   = mrl_q;
    mrd_d   = mrd_q;
    fv_d    = 1'b0;
    fl_d    = fl_q;
    fa_d    = fa_q;
    fi_d    = fi_q;
    fd_d    = fd_q;
    ack_d   = 2'b00;
    perr_d  = perr_q;

    // Two reads to the same line share one refill; lane 1 otherwise wins ties.
    merge = bus.req_valid1 & bus.req_valid2 & ~bus.req_write1 & ~bus.req_write2 &
            (bus.req_addr1[63:b+y] == bus.req_addr2[63:b+y]);
    if (bus.req_valid1) begin
      sel   = '{bus.req_write1, bus.req_size1, bus.req_addr1, bus.req_data1};
      grant = merge ? 2'b11 : 2'b01;
    end else begin
      sel   = '{bus.req_write2, bus.req_size2, bus.req_addr2, bus.req_data2};
      grant = 2'b10;
    end
    last_beat = (cnt_q == LAST_BEAT);

    case (state_q)
      IDLE: if (bus.req_valid1 || bus.req_valid2) begin
        req_d   = sel;
        lane_d  = grant;
        cnt_d   = '0;
        state_d = REQ;
        mrv_d   = 1'b1;
        mrw_d   = sel.write;
        mra_d   = sel.write ? sel.addr : (sel.addr & LINE_MASK);
        mrs_d   = sel.write ? sel.size : 3'd3;
        mrl_d   = sel.write ? 8'd0 : BURST_LEN;
        mrd_d   = sel.data;
      end
      REQ: if (bus.mem_req_ready) begin
        mrv_d   = 1'b0;
        mrw_d   = 1'b0;
        mra_d   = '0;
        mrs_d   = '0;
        mrl_d   = '0;
        mrd_d   = '0;
        state_d = req_q.write ? WRESP : RDATA;
      end
      RDATA: if (bus.mem_rvalid) begin
        fv_d  = 1'b1;
        fl_d  = ~lane_q[0];
        fa_d  = req_q.addr & LINE_MASK;
        fi_d  = cnt_q;
        fd_d  = bus.mem_rdata;
        cnt_d = cnt_q + b'(1);
        // The beat counter alone ends the burst; a misplaced rlast is only flagged.
        if (bus.mem_rlast != last_beat) perr_d = 1'b1;
        if (last_beat) begin
          state_d = DONE;
          ack_d   = lane_q;
        end
      end
      WRESP: if (bus.mem_bvalid) begin
        state_d = DONE;
        ack_d   = lane_q;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      lane_q  <= '0;
      cnt_q   <= '0;
      mrv_q   <= 1'b0;
      mrw_q   <= 1'b0;
      mra_q   <= '0;
      mrs_q   <= '0;
      mrl_q   <= '0;
      mrd_q   <= '0;
      fv_q    <= 1'b0;
      fl_q    <= 1'b0;
      fa_q    <= '0;
      fi_q    <= '0;
      fd_q    <= '0;
      ack_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      mrv_q   <= mrv_d;
      mrw_q   <= mrw_d;
      mra_q   <= mra_d;
      mrs_q   <= mrs_d;
      mrl_q   <= mrl_d;
      mrd_q   <= mrd_d;
      fv_q    <= fv_d;
      fl_q    <= fl_d;
      fa_q    <= fa_d;
      fi_q    <= fi_d;
      fd_q    <= fd_d;
      ack_q   <= ack_d;
      perr_q  <= perr_d;
    end
  end

  assign bus.mem_req_valid = mrv_q;
  assign bus.mem_req_write = mrw_q;
  assign bus.mem_req_addr  = mra_q;
  assign bus.mem_req_size  = mrs_q;
  assign bus.mem_req_len   = mrl_q;
  assign bus.mem_req_data  = mrd_q;
  assign bus.fill_valid    = fv_q;
  assign bus.fill_lane     = fl_q;
  assign bus.fill_addr     = fa_q;
  assign bus.fill_idx      = fi_q;
  assign bus.fill_data     = fd_q;
  assign bus.req_ack1      = ack_q[0];
  assign bus.req_ack2      = ack_q[1];
  assign bus.protocol_err  = perr_q;
  assign bus.busy          = (state_q != IDLE);

endmodule

// File: doc/dmem_miss_sequencer.md
# dmem_miss_sequencer

Sequences data-cache misses from the two superscalar MEM lanes onto the single memory-side request port. It grants one lane at a time, with lane 1 (older instruction) winning ties. For a read miss it issues a full-line burst and streams the refill beats to the cache data array. For a write miss it issues a single sized write and waits for the write response. When the transaction completes it pulses a per-lane acknowledge so the lane can clear its miss and stall.

## Interface
Parameters:
- B, 8, refill beats per line (64-bit words); power of two, 2..256
- b, 3, log2(B); width of beat index
- y, 3, byte-offset bits within a 64-bit word

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid1 / req_valid2  in  1  lane miss request; held until req_ack of that lane
- req_write1 / req_write2  in  1  1 = write miss, 0 = read (line refill) miss
- req_size1 / req_size2  in  3  write size code (0=b,1=h,2=w,3=d); ignored for reads
- req_addr1 / req_addr2  in  64  byte address
- req_data1 / req_data2  in  64  write data, right-aligned
- req_ack1 / req_ack2  out  1  one-cycle completion pulse
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_write  out  1  request is a write
- mem_req_addr  out  64  line-aligned for reads; byte address for writes
- mem_req_size  out  3  write size; 3 for reads
- mem_req_len  out  8  beats-1: B-1 for reads, 0 for writes
- mem_req_data  out  64  write data
- mem_rvalid  in  1  read beat valid
- mem_rdata  in  64  read beat data
- mem_rlast  in  1  last read beat
- mem_bvalid  in  1  write response
- fill_valid  out  1  refill beat valid to cache
- fill_lane  out  1  0 = lane 1, 1 = lane 2 (owner of the refill)
- fill_addr  out  64  line-aligned address of the refill
- fill_idx  out  b  beat index within the line
- fill_data  out  64  beat data
- busy  out  1  state != IDLE
- protocol_err  out  1  sticky; mem_rlast does not coincide with beat B-1

## Operation
- States: IDLE, REQ, RDATA, WRESP, DONE.
- IDLE grant rules:
  - If only one lane's req_valid is high, that lane is granted.
  - If both are high, lane 1 is granted.
  - Merge case: both lanes read (req_write=0) with equal addr[63:b+y]. A single refill is issued, and DONE acks both lanes in the same cycle.
- On grant, the sequencer latches addr, data, size, write and the lane id(s), then goes to REQ. Lane inputs are ignored until DONE.
- REQ: mem_req_* is driven from the latched values.
  - Read: mem_req_addr = {addr[63:b+y], 0}, len = B-1, size = 3.
  - Write: raw address, len = 0, latched size and data.
  - On mem_req_valid & mem_req_ready: read goes to RDATA, write goes to WRESP.
- RDATA: each mem_rvalid beat is registered to fill_* with fill_idx = beat counter. The counter increments mod B.
  - On beat B-1: go to DONE.
  - mem_rlast on a beat other than B-1, or missing on beat B-1, sets protocol_err. The counter alone governs completion.
- WRESP: on mem_bvalid, go to DONE. No fill_valid is produced for writes.
- DONE: assert req_ack for the granted lane(s) for one cycle, then return to IDLE.
- Requesters deassert req_valid on the edge after they see req_ack. A request still high in the cycle after DONE is treated as a new request.
- Reset values: all outputs 0, state IDLE, counter 0, protocol_err 0. Reset asserted mid-transaction aborts it silently; no ack is generated.

## Timing
- All outputs are registered, except busy (decoded from the state register).
- req_valid sampled high in IDLE at edge 0 gives mem_req_valid high from cycle 1. It holds, with all mem_req_* stable, until the ready handshake.
- Read beat accepted at edge k gives fill_valid high in cycle k+1 (exactly one cycle).
- Last fill_valid and req_ack are asserted in the same cycle.
- Back-to-back reads with mem_req_ready=1 and rvalid every cycle: ack at cycle B+2 after the request.
- mem_bvalid at edge k gives req_ack in cycle k+1.
- mem_rvalid/mem_bvalid outside RDATA/WRESP are ignored.
- Minimum one IDLE cycle between transactions.

## Test plan
- Lane 1 read miss, addr 0x1038, B=8, rdata = beat index: mem_req_addr=0x1000, len=7. fill_idx runs 0..7 with data 0..7 at fill_addr 0x1000. req_ack1 pulses with fill_idx=7; req_ack2 stays 0.
- Both lanes read, addrs 0x2008/0x2030: one request to 0x2000, 8 fills, req_ack1 and req_ack2 in the same cycle.
- Lane 1 write (size 2, 0x3004, data 0xDEADBEEF) and lane 2 read 0x4000 together: write issued first with len=0. bvalid gives req_ack1; the lane 2 refill then follows.
- mem_req_ready held low 5 cycles: mem_req_* stay stable for all 5 cycles, and the request transfers on the 6th.
- mem_rlast on beat 5 of 8: protocol_err goes to 1 and stays; refill still completes after beat 7.
- rst_n low during beat 3: all outputs 0 immediately. After release, state is IDLE, no ack, and a new request proceeds normally.
